// File: rtl/mipi_csi2_pkt_rx.sv
// -----------------------------------------------------------------------------
// mipi_csi2_pkt_rx
//
// Byte-level CSI-2 packet deframer. Takes the merged HS byte stream from the
// lane merger / SoT detector and splits it into a per-packet header record,
// a payload byte stream and a CRC verdict. The header ECC is checked but
// not corrected. The payload CRC-16 is checked. ECC and CRC errors are
// counted in saturating counters.
//
// Ports
//   clk, resetn         clock, asynchronous active-low reset
//   s_valid/s_data      input byte stream (always accepted, no backpressure)
//   s_sot               with s_valid: byte is the DI byte of a new burst
//   hdr_*               header record; hdr_valid is a one-cycle pulse and
//                       the fields hold until the next header
//   pld_valid/data/last payload bytes, one cycle after their input byte
//   crc_valid/crc_err   CRC verdict pulse (received != computed)
//   abort               one-cycle pulse: packet in progress cut by s_sot
//   ecc_err_cnt         saturating count of headers with a bad ECC
//   crc_err_cnt         saturating count of packets with a bad CRC
// -----------------------------------------------------------------------------
module mipi_csi2_pkt_rx #(
  parameter int unsigned CNT_W       = 16,
  parameter logic [5:0]  LONG_DT_MIN = 6'h10
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_sot,
  output logic             hdr_valid,
  output logic [1:0]       hdr_vc,
  output logic [5:0]       hdr_dt,
  output logic [15:0]      hdr_wc,
  output logic             hdr_long,
  output logic             hdr_ecc_err,
  output logic             pld_valid,
  output logic [7:0]       pld_data,
  output logic             pld_last,
  output logic             crc_valid,
  output logic             crc_err,
  output logic             abort,
  output logic [CNT_W-1:0] ecc_err_cnt,
  output logic [CNT_W-1:0] crc_err_cnt
);

  typedef enum logic [2:0] {
    IDLE,  // next byte is DI
    H1,    // next byte is WC[7:0]
    H2,    // next byte is WC[15:8]
    ECC,   // next byte is ECC
    PLD,   // payload bytes
    CRC0,  // next byte is CRC[7:0]
    CRC1   // next byte is CRC[15:8]
  } state_t;

  // CSI-2 header Hamming parity over D[23:0] = {WC[15:8], WC[7:0], DI}.
  function automatic logic [5:0] ecc_parity(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // CRC-16 x^16+x^12+x^5+1, reflected (0x8408), one byte LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_di;
  logic [7:0]       r_wc_lo;
  logic [7:0]       r_wc_hi;
  logic [15:0]      r_cnt;        // payload bytes still to come
  logic [15:0]      r_crc;        // running payload CRC
  logic [7:0]       r_rx_crc_lo;

  logic             r_hdr_valid;
  logic [1:0]       r_hdr_vc;
  logic [5:0]       r_hdr_dt;
  logic [15:0]      r_hdr_wc;
  logic             r_hdr_long;
  logic             r_hdr_ecc_err;
  logic             r_pld_valid;
  logic [7:0]       r_pld_data;
  logic             r_pld_last;
  logic             r_crc_valid;
  logic             r_crc_err;
  logic             r_abort;
  logic [CNT_W-1:0] r_ecc_cnt;
  logic [CNT_W-1:0] r_crc_cnt;

  logic [15:0]      w_wc;
  logic [5:0]       w_syndrome;
  logic             w_is_long;
  logic             w_pld_end;

  assign w_wc       = {r_wc_hi, r_wc_lo};
  // Only meaningful in ECC state, where s_data carries the ECC byte.
  assign w_syndrome = ecc_parity({r_wc_hi, r_wc_lo, r_di}) ^ s_data[5:0];
  assign w_is_long  = (r_di[5:0] >= LONG_DT_MIN);
  // Counter is loaded with WC and counts down, so WC = 16'hFFFF never wraps.
  assign w_pld_end  = (r_cnt == 16'd1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking (<=) so every register samples the
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt; otherwise a
    // latch is inferred.
    w_state_nxt = r_state;
    if (s_valid) begin
      if (s_sot) begin
        w_state_nxt = H1;
      end else begin
        case (r_state)
          IDLE: w_state_nxt = H1;
          H1:   w_state_nxt = H2;
          H2:   w_state_nxt = ECC;
          ECC: begin
            // A bad syndrome means WC is untrusted: drop the payload.
            if ((w_syndrome != 6'd0) || !w_is_long) w_state_nxt = IDLE;
            else if (w_wc == 16'd0)                 w_state_nxt = CRC0;
            else                                    w_state_nxt = PLD;
          end
          PLD:  if (w_pld_end) w_state_nxt = CRC0;
          CRC0: w_state_nxt = CRC1;
          CRC1: w_state_nxt = IDLE;
          default: w_state_nxt = IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_di          <= '0;
      r_wc_lo       <= '0;
      r_wc_hi       <= '0;
      r_cnt         <= '0;
      r_crc         <= '0;
      r_rx_crc_lo   <= '0;
      r_hdr_valid   <= 1'b0;
      r_hdr_vc      <= '0;
      r_hdr_dt      <= '0;
      r_hdr_wc      <= '0;
      r_hdr_long    <= 1'b0;
      r_hdr_ecc_err <= 1'b0;
      r_pld_valid   <= 1'b0;
      r_pld_data    <= '0;
      r_pld_last    <= 1'b0;
      r_crc_valid   <= 1'b0;
      r_crc_err     <= 1'b0;
      r_abort       <= 1'b0;
    end else begin
      // Pulses default low, so they also drop while the input is stalled.
      r_hdr_valid <= 1'b0;
      r_pld_valid <= 1'b0;
      r_pld_last  <= 1'b0;
      r_crc_valid <= 1'b0;
      r_abort     <= 1'b0;

      if (s_valid) begin
        if (s_sot || (r_state == IDLE)) begin
          r_di    <= s_data;
          r_abort <= s_sot && (r_state != IDLE);
        end else begin
          case (r_state)
            H1: r_wc_lo <= s_data;
            H2: r_wc_hi <= s_data;
            ECC: begin
              r_hdr_valid   <= 1'b1;
              r_hdr_vc      <= r_di[7:6];
              r_hdr_dt      <= r_di[5:0];
              r_hdr_wc      <= w_wc;
              r_hdr_long    <= w_is_long;
              r_hdr_ecc_err <= (w_syndrome != 6'd0);
              r_cnt         <= w_wc;
              r_crc         <= 16'hFFFF;
            end
            PLD: begin
              r_pld_valid <= 1'b1;
              r_pld_data  <= s_data;
              r_pld_last  <= w_pld_end;
              r_crc       <= crc16_byte(r_crc, s_data);
              r_cnt       <= r_cnt - 16'd1;
            end
            CRC0: r_rx_crc_lo <= s_data;
            CRC1: begin
              r_crc_valid <= 1'b1;
              r_crc_err   <= ({s_data, r_rx_crc_lo} != r_crc);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating error counters, stepped by the registered verdict pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ecc_cnt <= '0;
      r_crc_cnt <= '0;
    end else begin
      if (r_hdr_valid && r_hdr_ecc_err && (r_ecc_cnt != {CNT_W{1'b1}}))
        r_ecc_cnt <= r_ecc_cnt + CNT_W'(1);
      if (r_crc_valid && r_crc_err && (r_crc_cnt != {CNT_W{1'b1}}))
        r_crc_cnt <= r_crc_cnt + CNT_W'(1);
    end
  end

  assign hdr_valid   = r_hdr_valid;
  assign hdr_vc      = r_hdr_vc;
  assign hdr_dt      = r_hdr_dt;
  assign hdr_wc      = r_hdr_wc;
  assign hdr_long    = r_hdr_long;
  assign hdr_ecc_err = r_hdr_ecc_err;
  assign pld_valid   = r_pld_valid;
  assign pld_data    = r_pld_data;
  assign pld_last    = r_pld_last;
  assign crc_valid   = r_crc_valid;
  assign crc_err     = r_crc_err;
  assign abort       = r_abort;
  assign ecc_err_cnt = r_ecc_cnt;
  assign crc_err_cnt = r_crc_cnt;

endmodule
